// File: rtl/edge_det_flt_if.sv
// Pin-side bundle for edge_det_flt: async levels and controls in, filtered level,
// edge pulses, pending flags and interrupt out.
interface edge_det_flt_if #(
  parameter int CH_NUM = 8,
  parameter int FLT_W  = 4
);
  logic [CH_NUM-1:0]   dat_i;
  logic [CH_NUM-1:0]   en_i;
  logic [2*CH_NUM-1:0] mode_i;
  logic [FLT_W-1:0]    flt_thr_i;
  logic [CH_NUM-1:0]   clr_i;
  logic [CH_NUM-1:0]   dat_o;
  logic [CH_NUM-1:0]   re_o;
  logic [CH_NUM-1:0]   fe_o;
  logic [CH_NUM-1:0]   pend_o;
  logic                irq_o;

  modport master (
    output dat_i, en_i, mode_i, flt_thr_i, clr_i,
    input  dat_o, re_o, fe_o, pend_o, irq_o
  );

  modport slave (
    input  dat_i, en_i, mode_i, flt_thr_i, clr_i,
    output dat_o, re_o, fe_o, pend_o, irq_o
  );
endinterface

// File: rtl/edge_det_flt.sv
// Multi-channel synchroniser, glitch filter and edge detector with sticky
// pending flags and a combined interrupt.
module edge_det_flt #(
  parameter int CH_NUM   = 8,
  parameter int SYNC_STG = 2,
  parameter int FLT_W    = 4
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  edge_det_flt_if.slave bus
);

  logic [CH_NUM-1:0] sync_p0 [SYNC_STG];
  logic [CH_NUM-1:0] lvl_p1;
  logic [CH_NUM-1:0] re_p1;
  logic [CH_NUM-1:0] fe_p1;
  logic [FLT_W-1:0]  cnt_p1 [CH_NUM];
  logic [CH_NUM-1:0] pend_p2;
  logic [CH_NUM-1:0] rise_sel;
  logic [CH_NUM-1:0] fall_sel;
  logic [CH_NUM-1:0] smp;

  function automatic logic [FLT_W-1:0] sat_inc(input logic [FLT_W-1:0] v);
    return (&v) ? v : v + FLT_W'(1);
  endfunction

  // Stage 0: synchroniser chain
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int k = 0; k < SYNC_STG; k++) sync_p0[k] <= '0;
    end else begin
      sync_p0[0] <= bus.dat_i;
      for (int k = 1; k < SYNC_STG; k++) sync_p0[k] <= sync_p0[k-1];
    end
  end

  assign smp = sync_p0[SYNC_STG-1];

  // Stage 1: stability filter and edge pulses, both updated at the same edge
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      lvl_p1 <= '0;
      re_p1  <= '0;
      fe_p1  <= '0;
      for (int i = 0; i < CH_NUM; i++) cnt_p1[i] <= '0;
    end else begin
      for (int i = 0; i < CH_NUM; i++) begin
        re_p1[i] <= 1'b0;
        fe_p1[i] <= 1'b0;
        if (smp[i] == lvl_p1[i]) begin
          cnt_p1[i] <= '0;
        end else if (cnt_p1[i] >= bus.flt_thr_i) begin
          lvl_p1[i]  <= smp[i];
          cnt_p1[i]  <= '0;
          re_p1[i]   <= smp[i] & bus.en_i[i];
          fe_p1[i]   <= ~smp[i] & bus.en_i[i];
        end else begin
          cnt_p1[i] <= sat_inc(cnt_p1[i]);
        end
      end
    end
  end

  always_comb begin
    rise_sel = '0;
    fall_sel = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      rise_sel[i] = bus.mode_i[2*i];
      fall_sel[i] = bus.mode_i[2*i+1];
    end
  end

  // Stage 2: sticky pending; a set in the same cycle as a clear takes priority
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pend_p2 <= '0;
    end else begin
      pend_p2 <= (pend_p2 & ~bus.clr_i) | (re_p1 & rise_sel) | (fe_p1 & fall_sel);
    end
  end

  assign bus.dat_o  = lvl_p1;
  assign bus.re_o   = re_p1;
  assign bus.fe_o   = fe_p1;
  assign bus.pend_o = pend_p2;
  assign bus.irq_o  = |pend_p2;

endmodule

// File: tb/tb_edge_det_flt.sv
// Directed and randomized bench for edge_det_flt against a trailing-run model
// of the filter built from the history of synchronised samples.
module tb_edge_det_flt;
  localparam int CH_NUM   = 8;
  localparam int SYNC_STG = 2;
  localparam int FLT_W    = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  edge_det_flt_if #(.CH_NUM(CH_NUM), .FLT_W(FLT_W)) bus ();

  edge_det_flt #(.CH_NUM(CH_NUM), .SYNC_STG(SYNC_STG), .FLT_W(FLT_W)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  logic [CH_NUM-1:0] dq[$];
  logic [CH_NUM-1:0] shist[$];
  logic [CH_NUM-1:0] e_dat, e_re, e_fe, e_pend;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    dq.delete();
    for (int k = 0; k < SYNC_STG; k++) dq.push_back('0);
    shist.delete();
    e_dat  = '0;
    e_re   = '0;
    e_fe   = '0;
    e_pend = '0;
  endtask

  // Level follows the sampled input once it has disagreed for T+1 consecutive samples.
  task automatic model_edge();
    logic [CH_NUM-1:0] s, nd, nr, nf, np;
    int run;
    s = dq.pop_front();
    dq.push_back(bus.dat_i);
    shist.push_back(s);
    if (shist.size() > 16) void'(shist.pop_front());
    nd = e_dat;
    nr = '0;
    nf = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      run = 0;
      for (int k = shist.size() - 1; k >= 0; k--) begin
        if (shist[k][c] == e_dat[c]) break;
        run++;
      end
      if (run >= int'(bus.flt_thr_i) + 1) begin
        nd[c] = s[c];
        nr[c] = s[c] & bus.en_i[c];
        nf[c] = ~s[c] & bus.en_i[c];
      end
    end
    np = e_pend & ~bus.clr_i;
    for (int c = 0; c < CH_NUM; c++) begin
      if (e_re[c] && bus.mode_i[2*c])   np[c] = 1'b1;
      if (e_fe[c] && bus.mode_i[2*c+1]) np[c] = 1'b1;
    end
    e_dat  = nd;
    e_re   = nr;
    e_fe   = nf;
    e_pend = np;
  endtask

  task automatic compare(input string tag);
    check({tag, ".dat_o"},  32'(bus.dat_o),  32'(e_dat));
    check({tag, ".re_o"},   32'(bus.re_o),   32'(e_re));
    check({tag, ".fe_o"},   32'(bus.fe_o),   32'(e_fe));
    check({tag, ".pend_o"}, 32'(bus.pend_o), 32'(e_pend));
    check({tag, ".irq_o"},  32'(bus.irq_o),  32'(|e_pend));
    check({tag, ".re_fe_excl"}, 32'(bus.re_o & bus.fe_o), 32'(0));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    compare(tag);
  endtask

  task automatic run(input string tag, input int n);
    for (int k = 0; k < n; k++) tick(tag);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 model_reset();
    compare("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.dat_i     = '0;
    bus.en_i      = '1;
    bus.mode_i    = 16'b01_11_00_01_11_10_11_01;
    bus.flt_thr_i = '0;
    bus.clr_i     = '0;
    #1 model_reset();
    compare("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Latency with T=0 on ch0
    bus.dat_i[0] = 1'b1;
    run("lat", 2);
    check("lat_re_e2", 32'(bus.re_o[0]), 32'(0));
    tick("lat");
    check("lat_re_e3", 32'(bus.re_o[0]), 32'(1));
    check("lat_dat_e3", 32'(bus.dat_o[0]), 32'(1));
    tick("lat");
    check("lat_pend_e4", 32'(bus.pend_o[0]), 32'(1));
    check("lat_irq_e4", 32'(bus.irq_o), 32'(1));
    bus.clr_i[0] = 1'b1;
    tick("lat_clr");
    bus.clr_i[0] = 1'b0;
    check("lat_pend_clr", 32'(bus.pend_o[0]), 32'(0));

    // Glitch filter, T=3, ch1
    bus.flt_thr_i = 4'd3;
    run("idle", 4);
    bus.dat_i[1] = 1'b1;
    run("glitch3", 3);
    bus.dat_i[1] = 1'b0;
    run("glitch3", 8);
    check("glitch3_dat", 32'(bus.dat_o[1]), 32'(0));
    bus.dat_i[1] = 1'b1;
    run("glitch4", 4);
    bus.dat_i[1] = 1'b0;
    tick("glitch4");
    check("glitch4_re_e5", 32'(bus.re_o[1]), 32'(0));
    tick("glitch4");
    check("glitch4_re_e6", 32'(bus.re_o[1]), 32'(1));
    check("glitch4_dat_e6", 32'(bus.dat_o[1]), 32'(1));
    run("glitch4", 3);
    check("glitch4_fe_e9", 32'(bus.fe_o[1]), 32'(0));
    tick("glitch4");
    check("glitch4_fe_e10", 32'(bus.fe_o[1]), 32'(1));
    bus.clr_i = '1;
    tick("clr_all");
    bus.clr_i = '0;

    // Modes: ch2 fall-only, ch5 none, ch6 both
    bus.flt_thr_i = '0;
    bus.dat_i[2] = 1'b1;
    bus.dat_i[5] = 1'b1;
    bus.dat_i[6] = 1'b1;
    run("mode_rise", 5);
    check("mode10_pend_after_re", 32'(bus.pend_o[2]), 32'(0));
    check("mode11_pend_after_re", 32'(bus.pend_o[6]), 32'(1));
    bus.dat_i[2] = 1'b0;
    bus.dat_i[5] = 1'b0;
    bus.dat_i[6] = 1'b0;
    run("mode_fall", 5);
    check("mode10_pend_after_fe", 32'(bus.pend_o[2]), 32'(1));
    check("mode00_pend", 32'(bus.pend_o[5]), 32'(0));
    bus.clr_i = '1;
    tick("clr_all");
    bus.clr_i = '0;

    // Enable: ch3 rises while disabled
    bus.en_i[3]  = 1'b0;
    bus.dat_i[3] = 1'b1;
    run("en_off", 6);
    bus.en_i[3] = 1'b1;
    run("en_on", 3);
    check("en_dat", 32'(bus.dat_o[3]), 32'(1));
    check("en_pend", 32'(bus.pend_o[3]), 32'(0));
    bus.dat_i[3] = 1'b0;
    run("en_fall", 2);
    tick("en_fall");
    check("en_fe", 32'(bus.fe_o[3]), 32'(1));
    run("en_fall", 2);

    // Set/clear collision on ch4
    bus.clr_i[4] = 1'b1;
    bus.dat_i[4] = 1'b1;
    run("coll", 4);
    check("coll_set_wins", 32'(bus.pend_o[4]), 32'(1));
    tick("coll");
    check("coll_cleared", 32'(bus.pend_o[4]), 32'(0));
    bus.clr_i[4] = 1'b0;

    // Saturating count at T=15 on ch7 from a fresh reset
    bus.flt_thr_i = 4'd15;
    bus.dat_i = '0;
    do_reset();
    bus.dat_i[7] = 1'b1;
    run("sat", 17);
    check("sat_dat_e17", 32'(bus.dat_o[7]), 32'(0));
    tick("sat");
    check("sat_dat_e18", 32'(bus.dat_o[7]), 32'(1));
    check("sat_re_e18", 32'(bus.re_o[7]), 32'(1));

    // Reset mid-count
    bus.dat_i[7] = 1'b0;
    run("midcnt", 8);
    do_reset();
    run("post_rst", 4);

    // Randomized traffic
    bus.flt_thr_i = 4'd1;
    for (int n = 0; n < 600; n++) begin
      bus.dat_i = bus.dat_i ^ (CH_NUM'($urandom) & CH_NUM'($urandom));
      if ($urandom_range(0, 9) == 0) bus.en_i = CH_NUM'($urandom) | CH_NUM'($urandom);
      bus.clr_i = CH_NUM'($urandom) & CH_NUM'($urandom) & CH_NUM'($urandom);
      if ($urandom_range(0, 39) == 0) bus.flt_thr_i = FLT_W'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) bus.mode_i = 16'($urandom);
      tick("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/edge_det_flt.md
Name: edge_det_flt

Overview:
- Multi-channel, parametrised successor of the single-bit synchroniser plus edge detector.
- Each channel has four stages: configurable-depth synchroniser, glitch filter with programmable stability threshold, rise/fall detection, and per-channel mode selection.
- Matching edges set sticky pending flags with per-channel clear and a combined interrupt output.
- Used in GPIO/interrupt-controller front ends that sample asynchronous pins on a fast clock.

Parameters:
- CH_NUM, 8, number of independent input channels (>=1).
- SYNC_STG, 2, synchroniser flop stages per channel (>=2).
- FLT_W, 4, filter counter and threshold width (>=1).

Ports:
- clk_i  in  1  sampling clock.
- rst_n_i  in  1  asynchronous active-low reset.
- dat_i  in  CH_NUM  asynchronous input levels.
- en_i  in  CH_NUM  per-channel enable for edge pulses and pending set.
- mode_i  in  2*CH_NUM  per channel, bits [2i+1:2i]: 00 none, 01 rise, 10 fall, 11 both.
- flt_thr_i  in  FLT_W  shared filter threshold T, in clk_i cycles; 0 = no filtering.
- clr_i  in  CH_NUM  per-channel pending clear, level-sensitive, sampled each cycle.
- dat_o  out  CH_NUM  filtered, synchronised level.
- re_o  out  CH_NUM  one-cycle rising-edge pulse.
- fe_o  out  CH_NUM  one-cycle falling-edge pulse.
- pend_o  out  CH_NUM  sticky pending flags.
- irq_o  out  1  OR of pend_o.

Behaviour:
- Reset (async assert, sync release): all synchroniser flops, filter counters, dat_o, re_o, fe_o and pend_o are 0; irq_o is 0.
- Synchroniser: per channel, SYNC_STG-deep flop chain. s[i] is the last stage.
- Filter, per channel, with registered level f[i] = dat_o[i] and counter c[i] of FLT_W bits:
  - s==f: c<=0.
  - s!=f and c>=T: f<=s, c<=0 (update event).
  - s!=f and c<T: c<=c+1. c saturates at all-ones and never wraps.
  - Comparison is >=, so a runtime change of flt_thr_i takes effect on the next cycle. Lowering T mid-count may cause an immediate update.
  - A glitch at s shorter than T+1 consecutive cycles is rejected, and c returns to 0.
- Latency: if dat_i changes and stays stable before sampling edge 1, dat_o changes at edge SYNC_STG+1+T.
- Edge pulses are registered and set at the same edge as the f update:
  - re_o[i]=1 for exactly one cycle on an update event 0->1 while en_i[i]=1.
  - fe_o[i]=1 for exactly one cycle on an update event 1->0 while en_i[i]=1.
  - re_o and fe_o are never both high on one channel.
- en_i[i]=0:
  - The filter still tracks, so dat_o stays valid and enabling later produces no spurious edge.
  - re_o, fe_o and the pending set are suppressed for that channel.
- Pending flags:
  - pend_o[i] sets at the edge where re_o[i] rises with mode bit 0 set, or fe_o[i] rises with mode bit 1 set. It is registered one cycle after the pulse.
  - clr_i[i]=1 clears pend_o[i] at the next edge.
  - Simultaneous set and clear on the same cycle: set wins.
  - mode 00: pulses still generated, pend never set.
- irq_o: combinational OR of pend_o registers; glitch-free because every input is registered.
- Channels are fully independent; simultaneous events on different channels are all captured.
- dat_i high at reset release: f starts 0, so a rising edge is reported after the normal latency. This is intentional; software ignores or clears it.
- Reset asserted mid-filter or mid-pulse: all state returns to 0 immediately; no pulse is emitted on release beyond the dat_i-high case above.

Test Plan:
- Latency: SYNC_STG=2, T=0, ch0 mode 01, en=1, dat_i[0] 0->1 -> re_o[0] high one cycle at edge 3, dat_o[0]=1 same edge, pend_o[0]=1 at edge 4, irq_o=1; clr_i[0] one cycle -> pend_o[0]=0 next edge.
- Glitch filter: T=3, 3-cycle high pulse on dat_i[1] -> no re_o/fe_o and dat_o[1] stays 0. A 4-cycle pulse -> re_o at edge 6 (2+1+3), then fe_o 4 cycles later.
- Modes: ch2 mode 10, full pulse -> re_o and fe_o both pulse, pend only after fe_o. Mode 00 -> pulses, pend_o stays 0. Mode 11 -> pend after re_o.
- Enable: en_i[3]=0 during a 0->1 change, then en_i[3]=1 -> no re_o, no pend, dat_o[3]=1. Subsequent 1->0 -> fe_o.
- Set/clear collision: clr_i[4] held high while an edge on ch4 sets pend -> pend_o[4]=1 for that cycle, then cleared next edge.
- Reset and saturation: assert rst_n_i mid-count with T=15 -> all outputs 0. FLT_W=4, T=15 -> the counter reaches 15 without wrapping and dat_o updates at edge 2+1+15=18.
